mem_access_unit: RTL and testbench

- MEM-stage data memory access engine between the EX/MEM pipeline register and the MEM/WB register.
- Accepts one load or store per transaction and aligns it onto the word-wide data memory interface.
- Runs a request/acknowledge handshake with the variable-latency memory and stalls the pipeline while the access is in flight.
- Returns right-aligned raw load data to the writeback-stage load converter, which applies sign/zero extension using the same 6-bit operation code.

---
 rtl/mem_access_unit.sv | 279 +++++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : MEM-stage data memory access engine. Takes one load/store from
//            EX/MEM, aligns it onto a word-wide request/acknowledge memory
//            port, stalls the pipeline while the access is outstanding and
//            returns right-aligned raw load data (extension happens in WB).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   ADDR_WIDTH     - byte address width (also mem_addr width)
//   TIMEOUT_CYCLES - REQ cycles without ack before abort (1..255), only used
//                    when MEM_TIMEOUT_EN is defined
// Optional feature macro:
//   MEM_TIMEOUT_EN - adds the 8-bit ack timeout counter and mem_err reporting;
//                    when undefined REQ waits forever and mem_err is 0
// Ports:
//   clk, reset_n          - clock, asynchronous active-low reset
//   start, funct, addr,   - operation from EX/MEM (valid with start)
//   store_data, flush
//   busy                  - stall request (combinational in accept cycle)
//   done, misaligned,     - completion pulse and fault flags (valid with done)
//   mem_err
//   load_data             - right-aligned load result, upper bits zero
//   mem_req, mem_we,      - memory request port, held stable until mem_ack
//   mem_addr, mem_be,
//   mem_wdata
//   mem_rdata, mem_ack    - memory response
// ============================================================================
module mem_access_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [5:0]            funct,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           store_data,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           load_data,
  output logic                  misaligned,
  output logic                  mem_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack
);

  // Operation codes
  localparam logic [5:0] c_LB  = 6'b001011;
  localparam logic [5:0] c_LH  = 6'b001100;
  localparam logic [5:0] c_LW  = 6'b001101;
  localparam logic [5:0] c_LBU = 6'b001110;
  localparam logic [5:0] c_LHU = 6'b001111;
  localparam logic [5:0] c_SB  = 6'b010000;
  localparam logic [5:0] c_SH  = 6'b010001;
  localparam logic [5:0] c_SW  = 6'b010010;

  // Access sizes
  localparam logic [1:0] c_SZ_BYTE = 2'd0;
  localparam logic [1:0] c_SZ_HALF = 2'd1;
  localparam logic [1:0] c_SZ_WORD = 2'd2;

  // FSM states
  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_REQ  = 2'd1;
  localparam logic [1:0] c_S_DONE = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_size;
  logic                  r_is_load;
  logic                  r_we;
  logic [3:0]            r_be;
  logic [31:0]           r_wdata;
  logic                  r_misal;
  logic                  r_err;
  logic                  r_kill;
  logic [31:0]           r_load_data;

  logic                  w_valid;
  logic                  w_is_load;
  logic                  w_is_store;
  logic [1:0]            w_size;
  logic                  w_misal;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata;
  logic                  w_accept;
  logic                  w_in_req;
  logic                  w_ack;
  logic                  w_kill_now;
  logic                  w_timeout;
  logic [31:0]           w_shifted;
  logic [31:0]           w_ld;

  // --------------------------------------------------------------------------
  // Incoming operation decode: size, alignment, lane enables, replicated data
  // --------------------------------------------------------------------------
  always_comb begin
    w_valid   = 1'b0;
    w_is_load = 1'b0;
    w_size    = c_SZ_BYTE;
    case (funct)
      c_LB, c_LBU: begin w_valid = 1'b1; w_is_load = 1'b1; w_size = c_SZ_BYTE; end
      c_LH, c_LHU: begin w_valid = 1'b1; w_is_load = 1'b1; w_size = c_SZ_HALF; end
      c_LW:        begin w_valid = 1'b1; w_is_load = 1'b1; w_size = c_SZ_WORD; end
      c_SB:        begin w_valid = 1'b1; w_size = c_SZ_BYTE; end
      c_SH:        begin w_valid = 1'b1; w_size = c_SZ_HALF; end
      c_SW:        begin w_valid = 1'b1; w_size = c_SZ_WORD; end
      default:     begin w_valid = 1'b0; end
    endcase
  end

  assign w_is_store = w_valid & ~w_is_load;

  always_comb begin
    w_misal = 1'b0;
    w_be    = 4'b1111;
    w_wdata = store_data;
    case (w_size)
      c_SZ_BYTE: begin
        w_be    = 4'b0001 << addr[1:0];
        w_wdata = {4{store_data[7:0]}};
      end
      c_SZ_HALF: begin
        w_misal = addr[0];
        w_be    = addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{store_data[15:0]}};
      end
      default: begin
        w_misal = (addr[1:0] != 2'b00);
      end
    endcase
  end

  // A new operation may be taken in IDLE and also in DONE (back-to-back)
  assign w_accept   = ((r_state == c_S_IDLE) || (r_state == c_S_DONE)) &&
                      start && w_valid && !flush;
  assign w_in_req   = (r_state == c_S_REQ);
  assign w_ack      = w_in_req && mem_ack;
  // A flush in the very cycle the access ends still kills its completion
  assign w_kill_now = r_kill || flush;

  // Raw read word shifted down to the addressed lane, unused bits cleared
  assign w_shifted = mem_rdata >> {r_addr[1:0], 3'b000};
  always_comb begin
    case (r_size)
      c_SZ_BYTE: w_ld = {24'd0, w_shifted[7:0]};
      c_SZ_HALF: w_ld = {16'd0, w_shifted[15:0]};
      default:   w_ld = w_shifted;
    endcase
  end

  // --------------------------------------------------------------------------
  // Optional ack timeout
  // --------------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT_CYCLES);
  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= 8'd0;
    end else if (w_accept) begin
      r_cnt <= 8'd0;
    end else if (w_in_req) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Terminal count is the TIMEOUT_CYCLES-th REQ cycle; a coincident ack wins
  assign w_timeout = w_in_req && !mem_ack && ((r_cnt + 8'd1) == c_TIMEOUT);
`else
  assign w_timeout = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE, c_S_DONE: begin
        if (w_accept) begin
          w_state_nxt = w_misal ? c_S_DONE : c_S_REQ;
        end else begin
          w_state_nxt = c_S_IDLE;
        end
      end
      c_S_REQ: begin
        // Killed accesses finish their bus cycle but skip the DONE pulse
        if (w_ack || w_timeout) begin
          w_state_nxt = w_kill_now ? c_S_IDLE : c_S_DONE;
        end
      end
      default: w_state_nxt = c_S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    mem_req    = w_in_req;
    mem_we     = w_in_req & r_we;
    mem_addr   = w_in_req ? {r_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
    mem_be     = w_in_req ? r_be : 4'b0000;
    mem_wdata  = w_in_req ? r_wdata : 32'd0;
    done       = (r_state == c_S_DONE) && !flush;
    misaligned = done && r_misal;
    mem_err    = done && r_err;
    busy       = w_in_req ||
                 ((r_state == c_S_IDLE) && start && w_valid && !flush);
  end

  assign load_data = r_load_data;

  // --------------------------------------------------------------------------
  // Transaction registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr      <= '0;
      r_size      <= c_SZ_BYTE;
      r_is_load   <= 1'b0;
      r_we        <= 1'b0;
      r_be        <= 4'b0000;
      r_wdata     <= 32'd0;
      r_misal     <= 1'b0;
      r_err       <= 1'b0;
      r_kill      <= 1'b0;
      r_load_data <= 32'd0;
    end else begin
      if (w_accept) begin
        r_addr    <= addr;
        r_size    <= w_size;
        r_is_load <= w_is_load;
        r_we      <= w_is_store;
        r_be      <= w_be;
        r_wdata   <= w_wdata;
        r_misal   <= w_misal;
        r_err     <= 1'b0;
        r_kill    <= 1'b0;
        // A misaligned load completes with a zero result
        if (w_misal && w_is_load) begin
          r_load_data <= 32'd0;
        end
      end
      if (w_in_req) begin
        if (flush) begin
          r_kill <= 1'b1;
        end
        if (w_ack && !w_kill_now && r_is_load) begin
          r_load_data <= w_ld;
        end
        if (w_timeout && !w_kill_now) begin
          r_err <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit. A transaction-level
//            model derives per-cycle expectations from each operation's
//            code/address/ack delay; one negedge process compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int AW = 32;
  localparam int TO = 4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [5:0] LB = 6'b001011, LH = 6'b001100, LW = 6'b001101,
                         LBU = 6'b001110, LHU = 6'b001111,
                         SB = 6'b010000, SH = 6'b010001, SW = 6'b010010;

  logic          clk, reset_n, start, flush;
  logic [5:0]    funct;
  logic [AW-1:0] addr;
  logic [31:0]   store_data;
  logic          busy, done, misaligned, mem_err, mem_req, mem_we;
  logic [31:0]   load_data, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic          mem_ack;

  mem_access_unit #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .funct(funct), .addr(addr),
    .store_data(store_data), .flush(flush), .busy(busy), .done(done),
    .load_data(load_data), .misaligned(misaligned), .mem_err(mem_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (operation rules) ----------------
  function automatic bit f_valid(input logic [5:0] f);
    return (f >= 6'd11) && (f <= 6'd18);
  endfunction
  function automatic bit f_load(input logic [5:0] f);
    return (f >= 6'd11) && (f <= 6'd15);
  endfunction
  function automatic int f_bytes(input logic [5:0] f);
    if (f == LB || f == LBU || f == SB) return 1;
    if (f == LH || f == LHU || f == SH) return 2;
    return 4;
  endfunction
  function automatic bit f_mis(input logic [5:0] f, input logic [31:0] a);
    return (a % f_bytes(f)) != 0;
  endfunction
  function automatic logic [3:0] f_be(input logic [5:0] f, input logic [31:0] a);
    int n, off;
    n = f_bytes(f);
    off = int'(a % 4);
    return 4'(((1 << n) - 1) << off);
  endfunction
  function automatic logic [31:0] f_wd(input logic [5:0] f, input logic [31:0] sd);
    if (f_bytes(f) == 1) return (sd & 32'hFF) * 32'h01010101;
    if (f_bytes(f) == 2) return (sd & 32'hFFFF) * 32'h00010001;
    return sd;
  endfunction
  function automatic logic [31:0] f_ld(input logic [5:0] f, input logic [31:0] a,
                                        input logic [31:0] rd);
    logic [31:0] s;
    s = rd / (32'd1 << (8 * (a % 4)));
    if (f_bytes(f) == 1) return s % 32'h100;
    if (f_bytes(f) == 2) return s % 32'h10000;
    return s;
  endfunction

  // ---------------- per-cycle expectations ----------------
  bit          chk_en = 1'b0;
  logic        exp_busy, exp_req, exp_done, exp_mis, exp_err, exp_we;
  logic [31:0] exp_ld, exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  logic [31:0] model_ld = 32'd0;
  bit          pend_done, pend_mis, pend_err, pend_ld_upd;
  logic [31:0] pend_ld;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, exp_busy);
      chk("mem_req", mem_req, exp_req);
      chk("done", done, exp_done);
      chk("misaligned", misaligned, exp_mis);
      chk("mem_err", mem_err, exp_err);
      chk("load_data", load_data, exp_ld);
      if (exp_req) begin
        chk("mem_we", mem_we, exp_we);
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_be", mem_be, exp_be);
        chk("mem_wdata", mem_wdata, exp_wdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Completion expected in this cycle (from the previous operation), unless flushed
  task automatic set_done_exp(input bit fl);
    exp_done = pend_done && !fl;
    exp_mis  = exp_done && pend_mis;
    exp_err  = exp_done && pend_err;
    if (pend_done && pend_ld_upd) model_ld = pend_ld;
    exp_ld = model_ld;
    pend_done = 0; pend_mis = 0; pend_err = 0; pend_ld_upd = 0;
  endtask

  task automatic idle_cyc();
    start = 1'b0; flush = 1'b0;
    funct = 6'($urandom); addr = $urandom; store_data = $urandom;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    set_done_exp(1'b0);
    exp_busy = 1'b0; exp_req = 1'b0;
    tick();
  endtask

  // start with flush: never accepted, and any pending done is swallowed
  task automatic blocked_cyc();
    start = 1'b1; flush = 1'b1;
    funct = SW; addr = $urandom; store_data = $urandom;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    set_done_exp(1'b1);
    exp_busy = 1'b0; exp_req = 1'b0;
    tick();
  endtask

  // Issue one op; d = wait cycles before ack; fl = REQ cycle (1-based) with flush
  task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rd, input int d, input int fl, output bit killed);
    bit in_done, acked;
    int nreq;
    in_done = pend_done;
    killed  = 1'b0;
    start = 1'b1; funct = f; addr = a; store_data = sd; flush = 1'b0;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    set_done_exp(1'b0);
    exp_busy = f_valid(f) && !in_done;
    exp_req  = 1'b0;
    tick();
    if (!f_valid(f)) return;
    if (f_mis(f, a)) begin
      pend_done = 1; pend_mis = 1; pend_err = 0;
      pend_ld_upd = f_load(f); pend_ld = 32'd0;
      return;
    end
    acked = !TO_EN || (d < TO);
    nreq  = acked ? d + 1 : TO;
    exp_we = !f_load(f); exp_addr = a & ~32'd3;
    exp_be = f_be(f, a); exp_wdata = f_wd(f, sd);
    for (int i = 1; i <= nreq; i++) begin
      start = 1'($urandom_range(0, 1)); funct = 6'($urandom);
      addr = $urandom; store_data = $urandom;
      flush = (i == fl);
      mem_ack = acked && (i == nreq);
      mem_rdata = (i == nreq) ? rd : $urandom;
      exp_busy = 1'b1; exp_req = 1'b1;
      exp_done = 1'b0; exp_mis = 1'b0; exp_err = 1'b0; exp_ld = model_ld;
      tick();
    end
    if (fl >= 1 && fl <= nreq) begin
      killed = 1'b1;
    end else begin
      pend_done = 1; pend_mis = 0; pend_err = !acked;
      pend_ld_upd = acked && f_load(f); pend_ld = f_ld(f, a, rd);
    end
  endtask

  task automatic reset_mid();
    start = 1'b1; funct = LW; addr = 32'h40; store_data = 0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = $urandom;
    set_done_exp(1'b0);
    exp_busy = 1'b1; exp_req = 1'b0;
    tick();
    start = 1'b0; reset_n = 1'b0;
    pend_done = 0; pend_ld_upd = 0; model_ld = 32'd0;
    exp_busy = 0; exp_req = 0; exp_done = 0; exp_mis = 0; exp_err = 0; exp_ld = 0;
    #1;
    chk("rst_mid_req", mem_req, 1'b0);
    chk("rst_mid_be", mem_be, 4'b0000);
    tick();
    reset_n = 1'b1;
  endtask

  logic [5:0] ops [8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

  initial begin
    bit k;
    logic [5:0] f;
    reset_n = 1'b0; start = 0; flush = 0; funct = 0; addr = 0; store_data = 0;
    mem_ack = 0; mem_rdata = 0;
    pend_done = 0; pend_mis = 0; pend_err = 0; pend_ld_upd = 0; pend_ld = 0;
    exp_busy = 0; exp_req = 0; exp_done = 0; exp_mis = 0; exp_err = 0; exp_ld = 0;
    exp_we = 0; exp_addr = 0; exp_be = 0; exp_wdata = 0;
    tick();
    chk_en = 1'b1;
    tick(); tick();
    reset_n = 1'b1;
    idle_cyc();

    // Literal pins of the model rules
    chk("pin_be_lbu", f_be(LBU, 32'h103), 4'b1000);
    chk("pin_ld_lbu", f_ld(LBU, 32'h103, 32'hAB112233), 32'h000000AB);
    chk("pin_be_sh", f_be(SH, 32'h202), 4'b1100);
    chk("pin_wd_sh", f_wd(SH, 32'h0000CAFE), 32'hCAFECAFE);
    chk("pin_be_sb", f_be(SB, 32'h101), 4'b0010);
    chk("pin_wd_sb", f_wd(SB, 32'h5A), 32'h5A5A5A5A);

    // Directed scenarios
    do_op(LW, 32'h100, 0, 32'hDEADBEEF, 0, 0, k); idle_cyc();
    chk("pin_lw_data", load_data, 32'hDEADBEEF);
    do_op(LBU, 32'h103, 0, 32'hAB112233, 3, 0, k); idle_cyc();
    chk("pin_lbu_data", load_data, 32'h000000AB);
    do_op(LW, 32'h300, 0, 32'h12345678, 2, 1, k); idle_cyc(); idle_cyc();
    chk("pin_kill_data", load_data, 32'h000000AB);
    do_op(SH, 32'h202, 32'h0000CAFE, 32'h0, 0, 0, k); idle_cyc();
    do_op(LW, 32'h101, 0, 32'h0, 0, 0, k);
    chk("pin_mis_done", done, 1'b1);
    chk("pin_mis_flag", misaligned, 1'b1);
    chk("pin_mis_data", load_data, 32'h0);
    do_op(SB, 32'h101, 32'h5A, 32'h0, 1, 0, k); idle_cyc();
    do_op(LH, 32'h21, 0, 0, 0, 0, k); blocked_cyc(); idle_cyc();
    do_op(6'b111111, 32'h0, 0, 0, 0, 0, k); idle_cyc();
    reset_mid(); idle_cyc(); idle_cyc();
    do_op(LW, 32'h400, 0, 32'hCAFEF00D, 3, 0, k); idle_cyc();
    do_op(LW, 32'h404, 0, 32'h11111111, 10, 0, k); idle_cyc();
    do_op(SW, 32'h408, 32'h87654321, 0, 0, 0, k);
    do_op(LHU, 32'h40A, 0, 32'hBEEF0000, 0, 0, k); idle_cyc();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int r, d, fl;
      logic [31:0] a;
      r = $urandom_range(0, 99);
      if (r < 5) begin
        blocked_cyc();
      end else begin
        if (r < 10) begin
          f = 6'($urandom);
          if (f_valid(f)) f = 6'h3F;
        end else begin
          f = ops[$urandom_range(0, 7)];
        end
        a  = $urandom;
        d  = $urandom_range(0, 6);
        fl = ($urandom_range(0, 99) < 15) ? $urandom_range(1, d + 1) : 0;
        do_op(f, a, $urandom, $urandom, d, fl, k);
        if (k || ($urandom_range(0, 1) == 1)) idle_cyc();
      end
    end
    idle_cyc(); idle_cyc();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
